// File: rtl/imem_loader_pkg.sv
// Shared types and sizes for the instruction-memory loader.
// Address width matches the 8-bit program counter; one instruction is four bytes.
package imem_loader_pkg;
    localparam int ADDR_W         = 8;
    localparam int DATA_W         = 32;
    localparam int DEPTH          = 256;
    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_W          = ADDR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/byte_packer.sv
// Packs four bytes little-endian into one instruction; the word is presented
// combinationally as the fourth byte is accepted, so no extra latency is added.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_accept,
    input  logic [7:0]        i_byte,
    output logic [DATA_W-1:0] o_word,
    output logic              o_word_full
);
    logic [1:0]  r_cnt;
    logic [23:0] r_low;

    // Only the first three bytes are stored; the fourth is merged live into o_word.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt <= 2'd0;
            r_low <= 24'd0;
        end else if (i_clear) begin
            r_cnt <= 2'd0;
            r_low <= 24'd0;
        end else if (i_accept) begin
            r_cnt <= r_cnt + 2'd1;
            case (r_cnt)
                2'd0:    r_low[7:0]   <= i_byte;
                2'd1:    r_low[15:8]  <= i_byte;
                2'd2:    r_low[23:16] <= i_byte;
                default: r_low        <= r_low;
            endcase
        end
    end

    assign o_word_full = i_accept && (r_cnt == 2'd3);
    assign o_word      = {i_byte, r_low};
endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory one packed word per WRITE cycle, holding the CPU meanwhile.
// Five cycles per word at full byte rate; byte_ready drops during WRITE and outside a load.
module imem_loader
    import imem_loader_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_num_words,
    input  logic [7:0]        i_byte_data,
    input  logic              i_byte_valid,
    output logic              o_byte_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_cpu_hold
);
    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    r_word_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                w_accept;
    logic                w_clear;
    logic                w_word_full;
    logic                w_last_word;
    logic [DATA_W-1:0]   w_word;

    assign w_accept    = i_byte_valid && o_byte_ready;
    assign w_last_word = (r_word_cnt + CNT_W'(1)) == r_count;

    byte_packer u_packer (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (w_clear),
        .i_accept    (w_accept),
        .i_byte      (i_byte_data),
        .o_word      (w_word),
        .o_word_full (w_word_full)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = (i_num_words == '0) ? DONE : LOAD;
            LOAD:    if (w_word_full) w_next = WRITE;
            WRITE:   w_next = w_last_word ? DONE : LOAD;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_byte_ready = 1'b0;
        o_mem_we     = 1'b0;
        o_done       = 1'b0;
        o_busy       = 1'b1;
        w_clear      = 1'b0;
        case (r_state)
            IDLE: begin
                o_busy  = 1'b0;
                w_clear = i_start;
            end
            LOAD:    o_byte_ready = 1'b1;
            WRITE: begin
                o_mem_we = 1'b1;
                w_clear  = 1'b1;
            end
            DONE:    o_done = 1'b1;
            default: o_busy = 1'b0;
        endcase
    end

    assign o_cpu_hold  = o_busy;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;

    // The 8-bit address wraps to 0 naturally after the last word of a full 256-word load.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_count    <= '0;
            r_word_cnt <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            if (r_state == IDLE && i_start && i_num_words != '0) begin
                r_count    <= (i_num_words > DEPTH_CNT) ? DEPTH_CNT : i_num_words;
                r_word_cnt <= '0;
                r_addr     <= '0;
            end
            if (r_state == LOAD && w_word_full)
                r_wdata <= w_word;
            if (r_state == WRITE) begin
                r_addr     <= r_addr + ADDR_W'(1);
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, packing, gaps, zero/overflow counts,
// ignored restart and mid-load reset, checked against hand-computed values.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  num_words = 9'd0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready, mem_we, busy, done, cpu_hold;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    int n_done = 0;
    int wr_cyc = 0;
    int done_cyc = 0;
    int rdy_in_wr = 0;
    logic done_busy = 1'b0;

    imem_loader dut (
        .i_clk        (clk),
        .i_rst        (rst_n),
        .i_start      (start),
        .i_num_words  (num_words),
        .i_byte_data  (byte_data),
        .i_byte_valid (byte_valid),
        .o_byte_ready (byte_ready),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_busy       (busy),
        .o_done       (done),
        .o_cpu_hold   (cpu_hold)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            wr_cyc = cyc;
            if (byte_ready) rdy_in_wr++;
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
            done_busy = busy & cpu_hold;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        n_done = 0;
        rdy_in_wr = 0;
    endtask

    task automatic pulse_start(input logic [8:0] n);
        num_words = n;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        guard = 0;
        repeat (gap) step();
        byte_data = b;
        byte_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (byte_ready) break;
            guard++;
            if (guard > 50) begin
                checks++;
                failures++;
                $display("FAIL byte_accept: byte_ready never rose, got 0 required 1");
                break;
            end
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int k = 0; k < 4; k++)
            send_byte(w[8*k +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            step();
            n++;
        end
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", bound);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        checks++;
        if ({byte_ready, mem_we, mem_addr, mem_wdata, busy, done, cpu_hold} !== 45'd0) begin
            failures++;
            $display("FAIL reset_init: outputs=%h required 0",
                     {byte_ready, mem_we, mem_addr, mem_wdata, busy, done, cpu_hold});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_word();
        clear_mon();
        pulse_start(9'd1);
        checks++;
        if ({busy, cpu_hold, byte_ready} !== 3'b111) begin
            failures++;
            $display("FAIL single_load_state: busy/hold/ready=%b required 111", {busy, cpu_hold, byte_ready});
        end
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        send_byte(8'h50, 0);
        send_byte(8'h00, 0);
        wait_idle(20);
        checks++;
        if (wr_addr.size() != 1) begin
            failures++;
            $display("FAIL single_count: writes=%0d required 1", wr_addr.size());
        end else begin
            checks++;
            if (wr_addr[0] !== 8'h00 || wr_data[0] !== 32'h00500013) begin
                failures++;
                $display("FAIL single_data: addr=%h data=%h required 00 00500013", wr_addr[0], wr_data[0]);
            end
        end
        checks++;
        if (n_done != 1 || done_cyc != wr_cyc + 1) begin
            failures++;
            $display("FAIL single_done: done_count=%0d done_cyc=%0d required 1 at %0d", n_done, done_cyc, wr_cyc + 1);
        end
        checks++;
        if (done_busy !== 1'b1 || busy !== 1'b0 || cpu_hold !== 1'b0) begin
            failures++;
            $display("FAIL single_busy_fall: busy_at_done=%b busy_after=%b hold_after=%b required 1 0 0",
                     done_busy, busy, cpu_hold);
        end
    endtask

    task automatic test_async_reset();
        pulse_start(9'd1);
        send_byte(8'hAB, 0);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({byte_ready, mem_we, mem_addr, mem_wdata, busy, done, cpu_hold} !== 45'd0) begin
            failures++;
            $display("FAIL reset_async: outputs=%h required 0",
                     {byte_ready, mem_we, mem_addr, mem_wdata, busy, done, cpu_hold});
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_three_words_gaps();
        logic [31:0] exp_w[3];
        int bad;
        exp_w[0] = 32'h12345678;
        exp_w[1] = 32'hDEADBEEF;
        exp_w[2] = 32'h0000A5C3;
        clear_mon();
        pulse_start(9'd3);
        for (int i = 0; i < 3; i++) send_word(exp_w[i], 3);
        wait_idle(40);
        checks++;
        if (wr_addr.size() != 3) begin
            failures++;
            $display("FAIL gaps_count: writes=%0d required 3", wr_addr.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 3; i++)
                if (wr_addr[i] !== 8'(i) || wr_data[i] !== exp_w[i]) begin
                    bad++;
                    $display("FAIL gaps_word%0d: addr=%h data=%h required %h %h", i, wr_addr[i], wr_data[i], 8'(i), exp_w[i]);
                end
            checks++;
            if (bad != 0) failures++;
        end
        checks++;
        if (rdy_in_wr != 0 || n_done != 1) begin
            failures++;
            $display("FAIL gaps_ready_done: ready_in_write=%0d done_count=%0d required 0 1", rdy_in_wr, n_done);
        end
    endtask

    task automatic test_zero_words();
        clear_mon();
        pulse_start(9'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL zero_done: done=%b busy=%b required 1 1", done, busy);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || wr_addr.size() != 0) begin
            failures++;
            $display("FAIL zero_after: done=%b busy=%b writes=%0d required 0 0 0", done, busy, wr_addr.size());
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_w[256];
        int bad;
        for (int i = 0; i < 256; i++)
            exp_w[i] = {8'(i) ^ 8'h3C, ~8'(i), 8'(i), 8'hA5};
        clear_mon();
        pulse_start(9'd300);
        for (int i = 0; i < 256; i++) send_word(exp_w[i], 0);
        wait_idle(20);
        checks++;
        if (wr_addr.size() != 256) begin
            failures++;
            $display("FAIL overflow_count: writes=%0d required 256", wr_addr.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 256; i++)
                if (wr_addr[i] !== 8'(i) || wr_data[i] !== exp_w[i]) bad++;
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL overflow_data: bad_words=%0d required 0", bad);
            end
            checks++;
            if (wr_addr[255] !== 8'hFF || n_done != 1 || mem_addr !== 8'h00) begin
                failures++;
                $display("FAIL overflow_last: last_addr=%h done_count=%0d addr_after=%h required ff 1 00",
                         wr_addr[255], n_done, mem_addr);
            end
        end
    endtask

    task automatic test_start_while_busy();
        clear_mon();
        pulse_start(9'd2);
        send_byte(8'h01, 0);
        pulse_start(9'd5);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        send_word(32'h88776655, 0);
        wait_idle(20);
        checks++;
        if (wr_addr.size() != 2 || n_done != 1) begin
            failures++;
            $display("FAIL busy_start: writes=%0d done_count=%0d required 2 1", wr_addr.size(), n_done);
        end else begin
            checks++;
            if (wr_data[0] !== 32'h04030201 || wr_data[1] !== 32'h88776655 || wr_addr[1] !== 8'h01) begin
                failures++;
                $display("FAIL busy_start_data: d0=%h d1=%h a1=%h required 04030201 88776655 01",
                         wr_data[0], wr_data[1], wr_addr[1]);
            end
        end
    endtask

    task automatic test_reset_midload();
        clear_mon();
        pulse_start(9'd3);
        send_word(32'h11111111, 0);
        send_word(32'h22222222, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs: busy=%b we=%b done=%b required 0 0 0", busy, mem_we, done);
        end
        step();
        step();
        rst_n = 1'b1;
        byte_data = 8'h55;
        byte_valid = 1'b1;
        repeat (10) step();
        byte_valid = 1'b0;
        checks++;
        if (wr_addr.size() != 2 || n_done != 0) begin
            failures++;
            $display("FAIL midreset_abort: writes=%0d done_count=%0d required 2 0", wr_addr.size(), n_done);
        end
        clear_mon();
        pulse_start(9'd1);
        send_word(32'hCAFEF00D, 0);
        wait_idle(20);
        checks++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 8'h00 || wr_data[0] !== 32'hCAFEF00D || n_done != 1) begin
            failures++;
            $display("FAIL midreset_reload: writes=%0d addr=%h data=%h done_count=%0d required 1 00 cafef00d 1",
                     wr_addr.size(), (wr_addr.size() > 0) ? wr_addr[0] : 8'hxx,
                     (wr_data.size() > 0) ? wr_data[0] : 32'hx, n_done);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_async_reset();
        test_three_words_gaps();
        test_zero_words();
        test_start_while_busy();
        test_reset_midload();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Write-side companion to the instruction memory. Accepts a byte stream over a valid/ready handshake, packs each 4 bytes into a 32-bit instruction (little-endian), and writes it into the instruction memory at consecutive 8-bit addresses from 0. The CPU is held in reset while loading, so the program counter fetches only a complete program.

Parameters:
ADDR_W, 8, instruction memory address width (matches the 8-bit pc)
DATA_W, 32, instruction width
DEPTH, 256, number of instruction words (2**ADDR_W)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
start  input  1  one-cycle pulse; begins a load when idle
num_words  input  9  instructions to load (0..256)
byte_data  input  8  incoming program byte
byte_valid  input  1  byte_data valid
byte_ready  output  1  loader accepts byte this cycle
mem_we  output  1  instruction memory write enable
mem_addr  output  8  write address
mem_wdata  output  32  write data
busy  output  1  load in progress
done  output  1  one-cycle pulse: load complete
cpu_hold  output  1  hold CPU/program counter in reset

Behaviour:
- Reset (rst=0, async): state IDLE; byte_ready, mem_we, busy, done, cpu_hold = 0; mem_addr = 0; mem_wdata = 0; byte counter = 0; word counter = 0. Memory contents are not touched.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE: on start=1 with num_words>0, latch count = min(num_words, DEPTH), clear mem_addr and counters, go to LOAD. On start=1 with num_words=0, go directly to DONE. No start: stay.
- LOAD: byte_ready=1. A byte is accepted only when byte_valid && byte_ready. Byte k (k=0..3) goes to bits [8k+7:8k]. On acceptance of byte 3, go to WRITE next cycle. Bytes without valid are waited on indefinitely; there is no timeout.
- WRITE: exactly one cycle. mem_we=1, mem_addr = current word index, mem_wdata = assembled word. byte_ready=0. Next cycle: mem_addr+1 (wraps 255->0 only on the final word of a 256-word load) and word counter+1. If word counter reaches count, go to DONE; otherwise go to LOAD.
- DONE: one cycle. done=1, then IDLE.
- busy = cpu_hold = 1 in LOAD, WRITE and DONE; 0 in IDLE.
- Throughput: 4 accepted bytes -> write 1 cycle later, so 5 cycles per word at full rate.
- start while not IDLE: ignored. num_words is sampled only on the accepted start.
- num_words > 256: clamped to 256.
- mem_we is asserted only in WRITE, never in the same cycle as a byte acceptance.
- Reset mid-load: immediate abort. Words already written remain; the partial word is discarded; done is not pulsed.
- mem_addr and mem_wdata hold their last values outside WRITE.

Decomposition:
- Package imem_loader_pkg: state enum (IDLE, LOAD, WRITE, DONE), ADDR_W, DATA_W, DEPTH, BYTES_PER_WORD=4.
- Sub-module byte_packer: 2-bit byte counter and 32-bit shift/insert register with a word_full flag. Inputs are accept, byte and clear; the FSM clears it on start and after WRITE.

Test Plan:
- Reset values: drive rst=0 mid-simulation -> all outputs 0 within the same cycle, independent of clk.
- Single word: start with num_words=1, bytes 0x13,0x00,0x50,0x00 back-to-back -> one mem_we pulse with addr 0x00 and wdata 0x00500013; done 1 cycle later; busy/cpu_hold fall together with done.
- Three words with gaps: random byte_valid deassertion -> writes at addr 0,1,2 with correct packing; byte_ready=0 during every WRITE cycle; no bytes lost.
- Zero and overflow: num_words=0 -> done on the cycle after start with no mem_we. num_words=300 -> exactly 256 writes, last at addr 0xFF.
- Start while busy: second start during LOAD with num_words=5 (first was 2) -> exactly 2 writes total.
- Reset mid-load: rst=0 after 2 words plus 2 bytes -> no further mem_we and no done. A new load then starts again at addr 0.
